pri_encoder_ctrl: RTL

PRI_ENCODER_CTRL -- requirements
Module: pri_encoder_ctrl

---
 rtl/pri_encoder_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/pri_encoder_ctrl.sv
// Edge-captured 8-input priority encoder with ack handshake, enable gating,
// cascade enable-out and a sticky overflow flag for lost request edges.
module pri_encoder_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] _I,
    input  logic       _EI,
    input  logic       ack,
    input  logic       clr,
    output logic [2:0] A,
    output logic       valid,
    output logic       _GS,
    output logic       _EO,
    output logic       ovf
);

    logic [7:0] s1_q, s1_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] pending_q, pending_d;
    logic       ovf_q, ovf_d;

    logic [7:0] reqEdge;
    logic [7:0] capture;
    logic [7:0] ackMask;
    logic [2:0] topIdx;
    logic       anyPending;
    logic       ovfEvent;

    // Highest set pending bit wins because the loop visits bits in ascending order.
    always_comb begin
        topIdx = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                topIdx = i[2:0];
            end
        end
    end

    assign anyPending = |pending_q;

    always_comb begin
        valid = 1'b0;
        _GS   = 1'b1;
        _EO   = 1'b1;
        A     = 3'b111;
        if (!_EI) begin
            if (anyPending) begin
                valid = 1'b1;
                _GS   = 1'b0;
                A     = topIdx;
            end else begin
                _EO   = 1'b0;
            end
        end
    end

    assign ovf = ovf_q;

    // A falling request line shows up as prev=1, s1=0; ack only counts while a code is shown.
    always_comb begin
        reqEdge = prev_q & ~s1_q;
        capture = _EI ? 8'h00 : reqEdge;
        ackMask = 8'h00;
        if (valid && ack) begin
            ackMask = 8'h01 << topIdx;
        end
        ovfEvent  = |(capture & pending_q & ~ackMask);
        pending_d = (pending_q & ~ackMask) | capture;
        ovf_d     = ovfEvent | (ovf_q & ~clr);
        s1_d      = _I;
        prev_d    = s1_q;
    end

    // Resetting s1 to all-ones makes a line held low at release look like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 8'hFF;
            prev_q    <= 8'hFF;
            pending_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
